// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between the fetch port and the load/store port.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data always beats fetch.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;

    state_t           state_r, state_nxt_s;
    owner_t           owner_r, owner_nxt_s;
    owner_t           last_owner_r, last_owner_nxt_s;
    owner_t           winner_s;
    logic             owner_we_r, owner_we_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             done_s, accept_s, grant_s;

    // Arbitration: the response cycle doubles as an idle cycle so a new grant can overlap it
    always_comb begin
        done_s   = (state_r == ST_BUSY) && (cnt_r == CNT_W'(1));
        accept_s = rst_n && ((state_r == ST_IDLE) || done_s);
        grant_s  = accept_s && (if_req || d_req);
`ifdef MEM_ARB_RR_EN
        if (if_req && d_req) begin
            winner_s = (last_owner_r == OWN_IF) ? OWN_D : OWN_IF;
        end else if (d_req) begin
            winner_s = OWN_D;
        end else begin
            winner_s = OWN_IF;
        end
`else
        if (d_req) begin
            winner_s = OWN_D;
        end else begin
            winner_s = OWN_IF;
        end
`endif
    end

    // Next-state: a grant reloads the latency counter, otherwise count down while busy
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        owner_nxt_s      = owner_r;
        owner_we_nxt_s   = owner_we_r;
        last_owner_nxt_s = last_owner_r;
        if (grant_s) begin
            state_nxt_s      = ST_BUSY;
            cnt_nxt_s        = CNT_W'(MEM_LAT);
            owner_nxt_s      = winner_s;
            owner_we_nxt_s   = (winner_s == OWN_D) && d_we;
            last_owner_nxt_s = winner_s;
        end else if (done_s) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_W'(0);
        end else if (state_r == ST_BUSY) begin
            cnt_nxt_s = cnt_r - CNT_W'(1);
        end else begin
            state_nxt_s = ST_IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_W'(0);
            owner_r      <= OWN_IF;
            owner_we_r   <= 1'b0;
            last_owner_r <= OWN_IF;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            owner_r      <= owner_nxt_s;
            owner_we_r   <= owner_we_nxt_s;
            last_owner_r <= last_owner_nxt_s;
        end
    end

    // Grant and memory-side drive; a fetch is always a full-word read
    always_comb begin
        if_gnt    = grant_s && (winner_s == OWN_IF);
        d_gnt     = grant_s && (winner_s == OWN_D);
        mem_en    = grant_s;
        mem_we    = 1'b0;
        mem_be    = {BE_W{1'b0}};
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (d_gnt) begin
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_be   = {BE_W{1'b1}};
            mem_addr = if_addr;
        end else begin
            mem_we = 1'b0;
        end
    end

    // Response routing: only the owner sees read data; stores complete with zero data
    always_comb begin
        if_rvalid = done_s && (owner_r == OWN_IF);
        d_rvalid  = done_s && (owner_r == OWN_D);
        if (if_rvalid) begin
            if_rdata = mem_rdata;
        end else begin
            if_rdata = {DATA_W{1'b0}};
        end
        if (d_rvalid && !owner_we_r) begin
            d_rdata = mem_rdata;
        end else begin
            d_rdata = {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 uses MEM_LAT=1, instance 1 uses MEM_LAT=3,
// each backed by a small behavioural memory.
module tb_mem_port_arbiter;

    localparam int OW = 138;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0]       if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid, mem_en, mem_we;
    logic [1:0][31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0][3:0]  d_be, mem_be;
    logic             bd_we = 1'b0;
    int               bd_k = 0;
    logic [3:0]       bd_idx = 4'd0;
    logic [31:0]      bd_data = 32'd0;
    logic [31:0]      ref_mem [2][16];
    int               n_vec = 0;
    int               n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] mem [16];
        logic [31:0] pipe [3];

        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
            .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_be(d_be[g]), .d_addr(d_addr[g]),
            .d_wdata(d_wdata[g]), .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_be(mem_be[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );

        // Word memory with a fixed read pipeline of LAT stages
        always @(posedge clk) begin
            if (bd_we && bd_k == g) mem[bd_idx] <= bd_data;
            if (mem_en[g] && mem_we[g]) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[g][b]) mem[mem_addr[g][5:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
            end
            pipe[0] <= mem[mem_addr[g][5:2]];
            for (int j = 1; j < 3; j++) pipe[j] <= pipe[j-1];
        end
        assign mem_rdata[g] = pipe[LAT-1];
    end

    function automatic logic [OW-1:0] outs(input int k);
        return {if_gnt[k], if_rvalid[k], if_rdata[k], d_gnt[k], d_rvalid[k], d_rdata[k],
                mem_en[k], mem_we[k], mem_be[k], mem_addr[k], mem_wdata[k]};
    endfunction

    task automatic clr_inputs();
        if_req = 2'b00; d_req = 2'b00; d_we = 2'b00;
        if_addr = {2{32'd0}}; d_addr = {2{32'd0}}; d_wdata = {2{32'd0}}; d_be = {2{4'h0}};
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic bd_write(input int k, input int idx, input logic [31:0] data);
        bd_we = 1'b1; bd_k = k; bd_idx = 4'(idx); bd_data = data;
        ref_mem[k][idx] = data;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic test_reset();
        clr_inputs();
        rst_n = 1'b0;
        if_req = 2'b11; d_req = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (outs(k) !== {OW{1'b0}}) begin
                n_err++;
                $display("FAIL reset_outputs dut%0d: got %h expected 0", k, outs(k));
            end
        end
        @(posedge clk); #1;
        clr_inputs();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++) bd_write(k, i, $urandom);
    endtask

    task automatic test_fetch();
        logic [OW-1:0] exp;
        bd_write(0, 1, 32'h0150_0093);
        if_req[0] = 1'b1; if_addr[0] = 32'h4;
        @(negedge clk);
        exp = {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 4'hF, 32'h4, 32'd0};
        n_vec++;
        if (outs(0) !== exp) begin
            n_err++; $display("FAIL fetch_grant: got %h expected %h", outs(0), exp);
        end
        @(posedge clk); #1;
        if_req[0] = 1'b0;
        @(negedge clk);
        exp = {1'b0, 1'b1, 32'h0150_0093, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0};
        n_vec++;
        if (outs(0) !== exp) begin
            n_err++; $display("FAIL fetch_rvalid: got %h expected %h", outs(0), exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        logic [OW-1:0] exp;
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_be[0] = 4'hF; d_addr[0] = 32'h0; d_wdata[0] = 32'h54;
        @(negedge clk);
        exp = {1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 4'hF, 32'h0, 32'h54};
        n_vec++;
        if (outs(0) !== exp) begin
            n_err++; $display("FAIL store_grant: got %h expected %h", outs(0), exp);
        end
        @(posedge clk); #1;
        d_we[0] = 1'b0; d_wdata[0] = 32'd0;
        ref_mem[0][0] = 32'h54;
        @(negedge clk);
        exp = {1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd0, 1'b1, 1'b0, 4'hF, 32'h0, 32'd0};
        n_vec++;
        if (outs(0) !== exp) begin
            n_err++; $display("FAIL store_done_load_grant: got %h expected %h", outs(0), exp);
        end
        @(posedge clk); #1;
        d_req[0] = 1'b0;
        @(negedge clk);
        exp = {1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h54, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0};
        n_vec++;
        if (outs(0) !== exp) begin
            n_err++; $display("FAIL load_data: got %h expected %h", outs(0), exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        logic [OW-1:0] exp;
        logic          prev_d, wd, irv, drv;
        logic [31:0]   ird, drd;
        prev_d = 1'b0;
        pulse_reset();
        if_req[0] = 1'b1; if_addr[0] = 32'h8;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_be[0] = 4'hF; d_addr[0] = 32'hC; d_wdata[0] = 32'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            irv = (i > 0) && !prev_d;
            drv = (i > 0) && prev_d;
            ird = irv ? ref_mem[0][2] : 32'd0;
            drd = drv ? ref_mem[0][3] : 32'd0;
            wd  = RR ? (i % 2 == 0) : 1'b1;
            if (i == 4)
                exp = {1'b0, irv, ird, 1'b0, drv, drd, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0};
            else if (wd)
                exp = {1'b0, irv, ird, 1'b1, drv, drd, 1'b1, 1'b0, 4'hF, 32'hC, 32'd0};
            else
                exp = {1'b1, irv, ird, 1'b0, drv, drd, 1'b1, 1'b0, 4'hF, 32'h8, 32'd0};
            n_vec++;
            if (outs(0) !== exp) begin
                n_err++; $display("FAIL contention cyc %0d: got %h expected %h", i, outs(0), exp);
            end
            prev_d = wd;
            @(posedge clk); #1;
            if (i == 3) begin if_req[0] = 1'b0; d_req[0] = 1'b0; end
        end
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] exp;
        logic          g, rv;
        logic [31:0]   rd;
        if_req[1] = 1'b1; if_addr[1] = 32'h0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            g  = (c == 0) || (c == 3);
            rv = (c == 3) || (c == 6);
            rd = (c == 3) ? ref_mem[1][0] : ((c == 6) ? ref_mem[1][1] : 32'd0);
            exp = {g, rv, rd, 1'b0, 1'b0, 32'd0, g, 1'b0, g ? 4'hF : 4'h0,
                   (c == 3) ? 32'h4 : 32'h0, 32'd0};
            n_vec++;
            if (outs(1) !== exp) begin
                n_err++; $display("FAIL back_to_back cyc %0d: got %h expected %h", c, outs(1), exp);
            end
            @(posedge clk); #1;
            if (c == 0) if_addr[1] = 32'h4;
            if (c == 3) if_req[1] = 1'b0;
        end
    endtask

    task automatic test_reset_abort();
        logic [OW-1:0] exp;
        if_req[1] = 1'b1; if_addr[1] = 32'h8;
        @(negedge clk);
        exp = {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 4'hF, 32'h8, 32'd0};
        n_vec++;
        if (outs(1) !== exp) begin
            n_err++; $display("FAIL abort_grant: got %h expected %h", outs(1), exp);
        end
        @(posedge clk); #1;
        if_req[1] = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (outs(k) !== {OW{1'b0}}) begin
                n_err++; $display("FAIL abort_in_reset dut%0d: got %h expected 0", k, outs(k));
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++;
            if (outs(1) !== {OW{1'b0}}) begin
                n_err++; $display("FAIL abort_no_rvalid cyc %0d: got %h expected 0", c, outs(1));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_idle();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (outs(k) !== {OW{1'b0}}) begin
                    n_err++; $display("FAIL idle dut%0d cyc %0d: got %h expected 0", k, c, outs(k));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random(input int k, input int lat);
        logic          pi, pd, dwe, last_d, have_resp, resp_d, win_d, gnt, irv, drv;
        logic [31:0]   ia, da, dwd, resp_data, ird, drd;
        logic [3:0]    dbe;
        logic [OW-1:0] exp;
        int            free_cyc, resp_due;
        pi = 1'b0; pd = 1'b0; dwe = 1'b0; last_d = 1'b0; have_resp = 1'b0; resp_d = 1'b0;
        ia = 32'd0; da = 32'd0; dwd = 32'd0; dbe = 4'h0; resp_data = 32'd0;
        free_cyc = 0; resp_due = 0;
        pulse_reset();
        for (int c = 0; c < 400; c++) begin
            if (!pi && c < 380 && $urandom_range(0, 2) == 0) begin
                pi = 1'b1; ia = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            end
            if (!pd && c < 380 && $urandom_range(0, 1) == 0) begin
                pd = 1'b1; dwe = 1'($urandom_range(0, 1)); dbe = 4'($urandom_range(0, 15));
                da = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; dwd = $urandom;
            end
            if_req[k] = pi; if_addr[k] = ia;
            d_req[k] = pd; d_we[k] = dwe; d_be[k] = dbe; d_addr[k] = da; d_wdata[k] = dwd;
            @(negedge clk);
            irv = 1'b0; ird = 32'd0; drv = 1'b0; drd = 32'd0;
            if (have_resp && resp_due == c) begin
                if (resp_d) begin drv = 1'b1; drd = resp_data; end
                else begin irv = 1'b1; ird = resp_data; end
                have_resp = 1'b0;
            end
            gnt = (c >= free_cyc) && (pi || pd);
            if (pi && pd) win_d = RR ? !last_d : 1'b1;
            else win_d = pd;
            if (gnt && win_d)
                exp = {1'b0, irv, ird, 1'b1, drv, drd, 1'b1, dwe, dbe, da, dwd};
            else if (gnt)
                exp = {1'b1, irv, ird, 1'b0, drv, drd, 1'b1, 1'b0, 4'hF, ia, 32'd0};
            else
                exp = {1'b0, irv, ird, 1'b0, drv, drd, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0};
            n_vec++;
            if (outs(k) !== exp) begin
                n_err++;
                $display("FAIL random dut%0d cyc %0d: got %h expected %h", k, c, outs(k), exp);
            end
            if (gnt) begin
                have_resp = 1'b1; resp_due = c + lat; free_cyc = c + lat;
                resp_d = win_d; last_d = win_d;
                if (win_d) begin
                    resp_data = dwe ? 32'd0 : ref_mem[k][da[5:2]];
                    if (dwe)
                        for (int b = 0; b < 4; b++)
                            if (dbe[b]) ref_mem[k][da[5:2]][8*b +: 8] = dwd[8*b +: 8];
                    pd = 1'b0;
                end else begin
                    resp_data = ref_mem[k][ia[5:2]];
                    pi = 1'b0;
                end
            end
            @(posedge clk); #1;
        end
        clr_inputs();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_load();
        test_contention();
        test_back_to_back();
        test_reset_abort();
        test_idle();
        test_random(0, 1);
        test_random(1, 3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
